// File: rtl/port_sequencer.sv
// port_sequencer: buffers processor words in a small FIFO and
// replays them onto the GPIO port at a programmable interval.
module port_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int DIV_W = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_valid,
   input  logic [WIDTH-1:0]               wr_data,
   output logic                           wr_ready,
   input  logic                           enable,
   input  logic [DIV_W-1:0]               div,
   output logic                           cePortDir,
   output logic                           portDir,
   output logic                           cePortOut,
   output logic [WIDTH-1:0]               portData,
   output logic                           busy,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_EMIT  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_REL   = 3'd4;

   localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
   localparam logic [LW-1:0]    LVL_ZERO = '0;
   localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] CNT_ZERO = '0;

   logic [2:0]       state_q, state_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             push;
   logic             pop;
   logic [LW-1:0]    remaining;

   // Handshake and FIFO occupancy bookkeeping
   always_comb begin
      wr_ready  = (level_q != LVL_FULL);
      push      = wr_valid && wr_ready;
      pop       = (state_q == S_EMIT) && (level_q != LVL_ZERO);
      remaining = pop ? (level_q - LVL_ONE) : level_q;
      wptr_d    = push ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d    = pop ? (rptr_q + PTR_ONE) : rptr_q;
      level_d   = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_ONE;
      end else if (!push && pop) begin
         level_d = level_q - LVL_ONE;
      end
   end

   // Sequencer next-state and interval counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (enable && level_q != LVL_ZERO) begin
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            state_d = S_EMIT;
         end
         S_EMIT: begin
            cnt_d = div;
            if (div != CNT_ZERO) begin
               state_d = S_GAP;
            end else if (enable && remaining != LVL_ZERO) begin
               state_d = S_EMIT;
            end else begin
               state_d = S_REL;
            end
         end
         S_GAP: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               if (enable && level_q != LVL_ZERO) begin
                  state_d = S_EMIT;
               end else begin
                  state_d = S_REL;
               end
            end
         end
         S_REL: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore decode of port strobes from the state register
   always_comb begin
      cePortDir = (state_q == S_SETUP) || (state_q == S_REL);
      portDir   = (state_q == S_SETUP);
      cePortOut = (state_q == S_EMIT);
      portData  = (state_q == S_EMIT) ? mem_q[rptr_q] : '0;
      busy      = (state_q != S_IDLE);
      level     = level_q;
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= wr_data;
      end
   end

endmodule

// File: doc/port_sequencer.md
# port_sequencer

Sequencing front-end for the GPIO `port` block. It accepts data words from the processor over a valid/ready handshake and buffers them in a small FIFO. It then drives the port's direction and output-register strobes (`cePortDir`/`portDir`, `cePortOut`/`portData`), so that the buffered words appear on the pins one at a time at a programmable interval. After the last word it releases the port back to high-Z input mode.

## Interface
- `WIDTH`, 8: data word width; equals the downstream port's `WIDTH`.
- `DEPTH`, 4: FIFO depth in words; power of 2, ≥2.
- `DIV_W`, 8: width of the interval register.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_valid`, input, 1: processor offers `wr_data`.
- `wr_data`, input, WIDTH: word to emit.
- `wr_ready`, output, 1: FIFO can accept a word; equals `!full`.
- `enable`, input, 1: permits a sequence to start or continue.
- `div`, input, DIV_W: interval between emitted words, minus one.
- `cePortDir`, output, 1: direction-register write strobe to the port.
- `portDir`, output, 1: direction value (1 = output, 0 = input).
- `cePortOut`, output, 1: output-register write strobe to the port.
- `portData`, output, WIDTH: word written with `cePortOut`.
- `busy`, output, 1: FSM not in IDLE.
- `level`, output, $clog2(DEPTH+1): FIFO occupancy.

## Operation
- **FIFO**
  - A write occurs when `wr_valid && wr_ready`.
  - A pop occurs in EMIT.
  - `wr_ready` depends only on registered `level`. It is low when `level==DEPTH`, even if a pop happens in the same cycle.
  - A simultaneous write and pop leaves `level` unchanged.
  - Read and write pointers wrap modulo DEPTH.
- **Interval counter:** DIV_W bits. It loads `div` in EMIT and decrements in GAP. `div` is sampled only in EMIT; changes during GAP have no effect.
- **Words remaining:** `level` minus 1 if a pop happens this cycle. Writes in the same cycle are not counted.
- **FSM states:** IDLE, SETUP, EMIT, GAP, REL.
  - IDLE: if `enable && level!=0`, go to SETUP.
  - SETUP: `cePortDir=1`, `portDir=1`; go to EMIT.
  - EMIT:
    - `cePortOut=1`, `portData` = FIFO head; pop; load counter with `div`.
    - If `div!=0`, go to GAP.
    - Otherwise decide: if `enable` and words remaining are non-zero, go to EMIT; else go to REL.
  - GAP:
    - Decrement the counter.
    - When counter==1, decide: if `enable && level!=0`, go to EMIT; else go to REL.
    - Otherwise stay in GAP.
  - REL: `cePortDir=1`, `portDir=0`; go to IDLE.
- **Output decoding**
  - Strobe outputs are Moore decodes of the state register.
  - `portDir` is 0 outside SETUP.
  - `portData` equals the FIFO head in EMIT and is 0 otherwise.
- **Disable:** dropping `enable` never truncates a word already in EMIT. It takes effect at the next decision point, and the port is always released via REL.
- **Empty with `enable` high:** the FSM goes through REL to IDLE. A later write restarts the sequence with SETUP.

## Timing
- **Reset**
  - After the reset edge: state=IDLE, FIFO empty (`level=0`, pointers 0), counter=0.
  - Outputs: `wr_ready=1`, `busy=0`, `cePortDir=0`, `portDir=0`, `cePortOut=0`, `portData=0`.
  - Reset mid-sequence abandons all buffered words, and no REL pulse is issued. The downstream port is reset by the same `rst`.
- **Start latency:** with the IDLE condition true in cycle N, SETUP is in cycle N+1 and the first `cePortOut` is in cycle N+2.
- **Spacing:** consecutive `cePortOut` pulses are exactly `div+1` cycles apart. With `div=0`, they occur back-to-back every cycle.
- **Release:** REL follows the last EMIT by exactly `div+1` cycles, and IDLE follows REL by 1 cycle.
- **Write visibility:** a word written in cycle N is visible in `level` at N+1. It can be emitted no earlier than the decision in cycle N+1.

## Test plan
- **Reset:** assert `rst` during GAP with `level=3` → the next cycle shows IDLE, `level=0`, `wr_ready=1`, and all strobes 0.
- **Full FIFO:** with `enable=0` and `DEPTH=4`, write 0x11, 0x22, 0x33, 0x44, then 0x55 → `wr_ready` goes low after the 4th write and 0x55 is not accepted.
- **Back-to-back:** load 0xA1, 0xA2, 0xA3, set `div=0`, `enable=1` → expect the following sequence:
  - SETUP (`cePortDir=1`, `portDir=1`);
  - `cePortOut` on three consecutive cycles with 0xA1, 0xA2, 0xA3;
  - REL (`portDir=0`);
  - IDLE.
- **Spacing and `div` sampling:** with `div=3` and 2 words, expect `cePortOut` pulses 4 cycles apart and REL 4 cycles after the 2nd pulse. Changing `div` to 0 during GAP does not alter that spacing.
- **Disable:** drop `enable` during GAP with 2 words left → at counter==1 the FSM goes to REL and `level` stays 2. Re-asserting `enable` restarts with SETUP.
- **Simultaneous write and pop:** write while in EMIT with `level=DEPTH-1` → `level` is unchanged, and the written word is emitted last in order.
